// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the multi-cycle load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - default IO space base and the channel select offset of the input block
//   - funct3 legality helper
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'h1000;

  // addr[15:12] values at or above this select input channels
  localparam int IO_IN_SEL = 8;

  function automatic logic f3_legal(input logic wren, input logic [2:0] f3);
    if (wren) return (f3 == SB) || (f3 == SH) || (f3 == SW);
    else      return (f3 == LB) || (f3 == LH) || (f3 == LW) ||
                     (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for a two-word window.
// Ports:
//   offset    in  2   byte offset inside the first word
//   funct3    in  3   RV32I load/store funct3
//   st_data   in  32  right-aligned store data
//   rd_pair   in  64  {word i+1, word i} as read
//   byte_en   out 8   byte enables over {word i+1, word i}
//   st_pair   out 64  store data shifted into the word pair
//   crossing  out 1   access spills into word i+1
//   ld_data   out 32  extended load result
module lsu_lane_align (
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_data,
  input  logic [63:0] rd_pair,
  output logic [7:0]  byte_en,
  output logic [63:0] st_pair,
  output logic        crossing,
  output logic [31:0] ld_data
);
  import lsu_pkg::*;

  logic [3:0]  size_mask;
  logic [5:0]  shamt;
  logic [63:0] rd_shift;

  always_comb begin
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
    shamt    = {offset, 3'b000};
    byte_en  = {4'b0000, size_mask} << offset;
    st_pair  = {32'h0, st_data} << shamt;
    crossing = ((funct3[1:0] == 2'b01) && (offset == 2'b11)) ||
               ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    rd_shift = rd_pair >> shamt;
    case (funct3)
      LB:      ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      LH:      ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      LW:      ld_data = rd_shift[31:0];
      LBU:     ld_data = {24'h0, rd_shift[7:0]};
      LHU:     ld_data = {16'h0, rd_shift[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit with synchronous-read data memory,
// memory-mapped output registers and input channels, misaligned accesses
// spanning two words, and trap reporting.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req / o_ready         request handshake (accept when both high)
//   i_wren, i_funct3        store select, RV32I funct3
//   i_addr, i_st_data       byte address, right-aligned store data
//   o_valid                 one-cycle completion pulse
//   o_ld_data, o_trap       load result / rejection flag, valid with o_valid
//   i_io_in                 NUM_IN packed 32-bit input channels
//   o_io_out                NUM_OUT packed 32-bit output registers
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; word i read issued on accept
// ST_ACC0 | word i data present; store writes word i; issue read i+1
// ST_ACC1 | word i+1 data present; store writes upper bytes to i+1
// ST_RESP | o_valid pulse with result / trap
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int          DMEM_DEPTH = 2048,
  parameter int          NUM_OUT    = 4,
  parameter int          NUM_IN     = 2,
  parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req,
  output logic                    o_ready,
  input  logic                    i_wren,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_st_data,
  output logic                    o_valid,
  output logic [31:0]             o_ld_data,
  output logic                    o_trap,
  input  logic [NUM_IN*32-1:0]    i_io_in,
  output logic [NUM_OUT*32-1:0]   o_io_out
);

  localparam int AW = $clog2(DMEM_DEPTH);

  lsu_state_t state, state_nx;

  logic [1:0]            off_q;
  logic [2:0]            funct3_q;
  logic [31:0]           st_data_q;
  logic                  wren_q, trap_q, io_q, cross_q;
  logic [3:0]            sel_q;
  logic [AW-1:0]         idx_q;
  logic [31:0]           lo_q, ld_q;
  logic [NUM_OUT*32-1:0] io_out_q;

  logic [31:0]   mem [DMEM_DEPTH];
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [3:0]    mem_wbe;
  logic [31:0]   mem_wdata;

  logic          accept, f3_ok, io_hit, is_dmem, is_out, is_in, last_word, trap_now;
  logic [3:0]    sel;
  logic [AW-1:0] idx;

  logic [1:0]  al_off;
  logic [2:0]  al_f3;
  logic [31:0] al_st;
  logic [63:0] rd_pair, al_st_pair;
  logic [7:0]  al_be;
  logic        al_cross;
  logic [31:0] al_ld, io_word, rd_word;

  // In IDLE the aligner decodes the incoming request (for crossing/trap);
  // afterwards it works on the captured request.
  assign al_off = (state == ST_IDLE) ? i_addr[1:0] : off_q;
  assign al_f3  = (state == ST_IDLE) ? i_funct3    : funct3_q;
  assign al_st  = (state == ST_IDLE) ? i_st_data   : st_data_q;

  lsu_lane_align u_align (
    .offset   (al_off),
    .funct3   (al_f3),
    .st_data  (al_st),
    .rd_pair  (rd_pair),
    .byte_en  (al_be),
    .st_pair  (al_st_pair),
    .crossing (al_cross),
    .ld_data  (al_ld)
  );

  // request decode
  assign accept    = i_req && (state == ST_IDLE);
  assign sel       = i_addr[15:12];
  assign idx       = i_addr[AW+1:2];
  assign f3_ok     = f3_legal(i_wren, i_funct3);
  assign is_dmem   = (i_addr >> (AW + 2)) == 32'd0;
  assign io_hit    = (i_addr[31:16] == IO_BASE);
  assign is_out    = io_hit && ({28'd0, sel} < 32'(NUM_OUT));
  assign is_in     = io_hit && ({28'd0, sel} >= 32'(IO_IN_SEL)) &&
                     ({28'd0, sel} < 32'(IO_IN_SEL + NUM_IN));
  assign last_word = (idx == AW'(DMEM_DEPTH - 1));
  // a crossing access may not wrap past the last DMEM word or touch IO
  assign trap_now  = !f3_ok || !(is_dmem || is_out || is_in) ||
                     (is_in && i_wren) ||
                     (al_cross && (!is_dmem || last_word));

  always_comb begin
    io_word = 32'h0;
    for (int k = 0; k < NUM_OUT; k++)
      if (sel_q == 4'(k)) io_word = io_out_q[k*32 +: 32];
    for (int k = 0; k < NUM_IN; k++)
      if (sel_q == 4'(IO_IN_SEL + k)) io_word = i_io_in[k*32 +: 32];
  end

  assign rd_word = io_q ? io_word : mem_rdata;
  assign rd_pair = (state == ST_ACC1) ? {mem_rdata, lo_q} : {32'h0, rd_word};

  // data memory: one write port, one synchronous read port
  assign mem_we    = !i_reset && wren_q && !io_q &&
                     ((state == ST_ACC0) || (state == ST_ACC1));
  assign mem_waddr = (state == ST_ACC1) ? idx_q + AW'(1) : idx_q;
  assign mem_wbe   = (state == ST_ACC1) ? al_be[7:4] : al_be[3:0];
  assign mem_wdata = (state == ST_ACC1) ? al_st_pair[63:32] : al_st_pair[31:0];
  assign mem_raddr = (state == ST_IDLE) ? idx : idx_q + AW'(1);

  always_ff @(posedge i_clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wbe[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    mem_rdata <= mem[mem_raddr];
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (i_req) state_nx = trap_now ? ST_RESP : ST_ACC0;
      ST_ACC0: state_nx = cross_q ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_ready = (state == ST_IDLE);
    o_valid = (state == ST_RESP);
    o_trap  = (state == ST_RESP) && trap_q;
  end

  assign o_ld_data = ld_q;
  assign o_io_out  = io_out_q;

  // request capture, load assembly and IO register writes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      off_q     <= 2'b00;
      funct3_q  <= 3'b000;
      st_data_q <= 32'h0;
      wren_q    <= 1'b0;
      trap_q    <= 1'b0;
      io_q      <= 1'b0;
      cross_q   <= 1'b0;
      sel_q     <= 4'h0;
      idx_q     <= '0;
      lo_q      <= 32'h0;
      ld_q      <= 32'h0;
      io_out_q  <= '0;
    end else begin
      if (accept) begin
        off_q     <= i_addr[1:0];
        funct3_q  <= i_funct3;
        st_data_q <= i_st_data;
        wren_q    <= i_wren;
        trap_q    <= trap_now;
        io_q      <= is_out || is_in;
        cross_q   <= al_cross;
        sel_q     <= sel;
        idx_q     <= idx;
        if (trap_now) ld_q <= 32'h0;
      end
      if (state == ST_ACC0) begin
        lo_q <= rd_word;
        if (wren_q && io_q)
          for (int k = 0; k < NUM_OUT; k++)
            if (sel_q == 4'(k))
              for (int b = 0; b < 4; b++)
                if (al_be[b]) io_out_q[k*32 + b*8 +: 8] <= al_st_pair[b*8 +: 8];
        if (!cross_q) ld_q <= wren_q ? 32'h0 : al_ld;
      end
      if (state == ST_ACC1) ld_q <= wren_q ? 32'h0 : al_ld;
    end
  end

endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
- Multi-cycle, parametrised load/store unit for the rv32i core.
- Replaces the single-cycle LSU: synchronous-read data memory with configurable depth, and a configurable number of memory-mapped output and input IO channels.
- Adds a req/ready/valid handshake, hardware support for misaligned accesses that span two words, and trap reporting for illegal or unmapped accesses.
- Sits between the execute stage and the board IO (LEDs, LCD, switches).

Parameters:
- DMEM_DEPTH, 2048: data memory depth in 32-bit words; power of two, at least 4.
- NUM_OUT, 4: number of 32-bit output IO registers; 1..8.
- NUM_IN, 2: number of 32-bit input IO channels; 1..8.
- IO_BASE, 16'h1000: value of addr[31:16] that selects IO space.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  1  request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_wren  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I load/store funct3.
- i_addr  in  32  byte address.
- i_st_data  in  32  store data, right-aligned.
- o_valid  out  1  one-cycle completion pulse, for loads and stores.
- o_ld_data  out  32  extended load result; valid while o_valid=1.
- o_trap  out  1  access rejected; valid while o_valid=1.
- i_io_in  in  NUM_IN*32  input channels; channel k occupies bits [32k+31:32k].
- o_io_out  out  NUM_OUT*32  output registers, same packing as i_io_in.

Behaviour:
- Handshake
  - A request is accepted on an edge where i_req & o_ready = 1.
  - The request's addr, funct3, wren and st_data are captured on that edge.
  - o_ready=1 only in state IDLE.
- Reset values
  - o_ready=1, o_valid=0, o_ld_data=0, o_trap=0, all o_io_out=0, state=IDLE.
  - Memory contents are not reset.
- Address map
  - DMEM: addr[31:16]==0. Word index is addr[log2(DMEM_DEPTH)+1:2]. Byte address at or above DMEM_DEPTH*4 → trap.
  - Output channel k: addr[31:16]==IO_BASE and addr[15:12]==k, for k<NUM_OUT. Read/write.
  - Input channel k: addr[15:12]==8+k, for k<NUM_IN. Read-only; a store → trap.
  - Any other address → trap.
- Legal funct3
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else → trap.
- Crossing accesses
  - A "crossing" access is halfword at offset 3, or word at offset 1, 2 or 3.
  - Allowed in DMEM only. In IO space → trap.
  - If the second word index equals DMEM_DEPTH → trap; no wrap-around.
- States: IDLE, ACC0, ACC1, RESP.
  - IDLE → accept: trap detected → RESP; else → ACC0. The read of word i is issued on the accept edge.
  - ACC0: capture rdata of word i. A store writes word i with byte enables on this edge. Crossing → ACC1 (read of i+1 issued); else → RESP.
  - ACC1: capture word i+1; a store writes the upper bytes to i+1. → RESP.
  - RESP: o_valid=1 for exactly one cycle. → IDLE.
- Latency (accept cycle = 0)
  - Trap: o_valid in cycle 1.
  - Aligned: o_valid in cycle 2.
  - Crossing: o_valid in cycle 3.
  - Next accept is possible in the cycle after RESP.
- Loads
  - Select bytes from {word(i+1), word(i)} starting at offset addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- IO behaviour
  - IO loads sample i_io_in / o_io_out in ACC0.
  - IO stores use byte enables on o_io_out[k]; SB/SH update only the addressed lanes.
- Traps
  - A trap causes no memory or IO side effect.
  - o_ld_data=0, o_trap=1.
- Store visibility: a store's effect is visible to any load accepted after its o_valid.
- Reset mid-operation
  - Returns to IDLE immediately; no o_valid is produced.
  - A crossing store interrupted in ACC1 has word i written and word i+1 unchanged.
- Inputs i_req/i_addr are ignored when o_ready=0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - state enum;
  - IO_BASE default;
  - IO input select offset (8).
- Sub-module lsu_lane_align (combinational):
  - from offset, funct3 and st_data, produce 8-bit byte enables and 64-bit shifted data for the word pair, plus the crossing flag;
  - from the 64-bit read pair, produce the extended load result.

Test Plan:
- SW 0x11223344 @0x10, then LW @0x10 → o_valid in cycle 2, data 0x11223344. LB @0x13 → 0x00000011. LBU @0x10 → 0x00000044.
- Word 0=0xAABBCCDD, word 1=0x11223344; LW @0x2 → o_valid in cycle 3, data 0x3344AABB. LH @0x3 → 0x000044AA.
- SH 0x00008765 @0x7 → word 1 byte 3=0x65, word 2 byte 0=0x87, all other bytes unchanged. LHU @0x7 → 0x00008765.
- SW 0xDEADBEEF @0x10001000 → o_io_out[1]=0xDEADBEEF. SB 0x12 @0x10001002 → 0xDE12BEEF. i_io_in[0]=0x5A, LW @0x10008000 → 0x0000005A.
- Each of: LW @0x00002000 (DEPTH=2048), SW @0x10008000, LW @0x10000001, LW @0x1FFE, funct3=011 → o_valid in cycle 1, o_trap=1, no state change.
- Assert i_reset while in ACC1 of SW 0xCAFEF00D @0x2 → IDLE next cycle, no o_valid, o_ready=1. Word 0 upper half = 0xF00D, word 1 unchanged.
